device_data_framer: RTL and testbench
=====================================

Name: device_data_framer

Overview:
- Consumer end of the TR_IN / ADDR_IN / DATA_IN / TR_IN_BUSY word interface that the device-data collectors drive.
- Accepts 16-bit address / 32-bit data words through a one-deep holding register.
- Serialises each word into an 8-byte checksummed frame on a byte-wide valid/ready stream for the uplink (UART/Ethernet byte sink).
- Runs entirely in the TR_CLK domain.

Parameters:
SYNC_BYTE, 8'hA5, first byte of every frame
DROP_CNT_W, 16, width of saturating drop counter

Ports:
TR_CLK  in  1  clock
RESET_N  in  1  reset; RESET_N asynchronous, active-low; clock TR_CLK
TR_IN  in  1  word strobe from collector; a word is offered on its rising edge
ADDR_IN  in  16  word address, valid when TR_IN rises
DATA_IN  in  32  word data, valid when TR_IN rises
TR_IN_BUSY  out  1  high while the holding register is occupied; source must not raise TR_IN
TX_DATA  out  8  frame byte
TX_VALID  out  1  TX_DATA valid
TX_READY  in  1  sink accepts byte when TX_VALID and TX_READY are both high
FRAME_CNT  out  32  completed frames, wraps at 2^32
DROP_CNT  out  DROP_CNT_W  words lost to a TR_IN rise while busy, saturating

Behaviour:
- Reset values: TR_IN_BUSY=0, TX_VALID=0, TX_DATA=0, FRAME_CNT=0, DROP_CNT=0, holding register empty, FSM=IDLE.
- The TR_IN edge detector register resets to 1. A TR_IN that is already high at reset release is ignored until it has gone low.
- Edge detection:
  - The source may hold TR_IN high for several cycles. Only the 0->1 transition (TR_IN=1, previous sample=0) is an offer.
  - An offer with holding register empty: capture ADDR_IN/DATA_IN on that edge. TR_IN_BUSY=1 from the next cycle.
  - An offer with holding register full: the word is discarded. DROP_CNT+1, saturating at all-ones. Held word and frame in progress are unaffected.
- TR_IN_BUSY is registered and equals holding-register-occupied.
- FSM states: IDLE, SYNC, AH, AL, D3, D2, D1, D0, CHK.
  - IDLE with holding register full: next cycle move the word into the shift/frame register, clear the holding register (TR_IN_BUSY=0), enter SYNC with TX_VALID=1.
  - Latency: TR_IN rising at edge k → BUSY=1 at k+1 → TX_VALID=1 with TX_DATA=SYNC_BYTE at k+2, BUSY=0 at k+2.
- Byte order and TX_DATA per state:
  - SYNC = SYNC_BYTE
  - AH = ADDR[15:8], AL = ADDR[7:0]
  - D3 = DATA[31:24], D2 = DATA[23:16], D1 = DATA[15:8], D0 = DATA[7:0]
  - CHK = (AH+AL+D3+D2+D1+D0) mod 256. SYNC_BYTE is excluded. Accumulate with an 8-bit adder as bytes are sent, or compute at load.
- Advance one state on each cycle with TX_VALID&TX_READY. TX_DATA and TX_VALID must hold stable while TX_VALID=1 and TX_READY=0. No cap on stall length.
- On the CHK handshake:
  - FRAME_CNT+1, wrapping.
  - Holding register full: load it and go directly to SYNC. TX_VALID stays 1, so there is no idle bubble between frames.
  - Holding register empty: go to IDLE, TX_VALID=0.
- Same-cycle events:
  - A new capture and the FSM draining the holding register in the same cycle cannot collide, because capture requires BUSY=0.
  - A capture in the same cycle as the CHK handshake while the holding register is empty goes to the holding register. The FSM goes to IDLE and loads it the following cycle.
- Continuous TR_IN offers with TX_READY=1: one word per 8 cycles sustained. Further offers while BUSY are dropped and counted.
- Reset asserted mid-frame: immediate abort. TX_VALID=0 asynchronously; held word lost. Counters cleared; no partial frame resumes after release.
- No X on any output after reset. ADDR_IN/DATA_IN are sampled only on the accepted edge cycle.

Test Plan:
1. Single word ADDR=0x012C, DATA=0x12345678, TX_READY=1 → bytes A5 01 2C 12 34 56 78 41 on 8 consecutive cycles starting 2 cycles after TR_IN rise; FRAME_CNT=1; BUSY high exactly 1 cycle.
2. Same word with TX_READY toggling 1-0-0-1 per cycle → identical byte sequence; TX_DATA constant throughout each stall; no duplicated or skipped byte.
3. TX_READY=0 held; offer words A (0x0001/0x00000001), then B (0x0002/0x00000002) after TR_IN low, then C → A in frame register, B held (BUSY=1), C dropped, DROP_CNT=1. Release TR_READY → frame A, then frame B back-to-back with no TX_VALID gap (B checksum 0x04); FRAME_CNT=2.
4. TR_IN held high for 5 cycles with one rising edge → exactly one frame, DROP_CNT=0. TR_IN high across reset release → no frame until a fresh 0->1 edge.
5. Assert RESET_N low while in state D2 → TX_VALID=0, counters 0 immediately. After release and a new word 0xFFFF/0xFFFFFFFF → frame A5 FF FF FF FF FF FF FA.
6. Force 65 536 drops with DROP_CNT_W=16 → DROP_CNT saturates at 0xFFFF and stays; frames still emitted normally afterwards.

Source files
------------

// File: rtl/device_data_framer.sv
// -----------------------------------------------------------------------------
// device_data_framer
//
// Consumer end of the collector word interface. A rising edge on TR_IN offers a
// 16-bit address / 32-bit data word. The word is parked in a one-deep holding
// register and then serialised into an 8-byte checksummed frame on a byte-wide
// valid/ready stream:
//
//     SYNC_BYTE, ADDR[15:8], ADDR[7:0], DATA[31:24], DATA[23:16],
//     DATA[15:8], DATA[7:0], CHK
//
// CHK is the 8-bit sum of the six address/data bytes (SYNC_BYTE excluded).
//
// Ports
//   TR_CLK      in   clock
//   RESET_N     in   asynchronous active-low reset
//   TR_IN       in   word strobe; only a 0->1 transition is an offer
//   ADDR_IN     in   [15:0] word address, sampled on the accepted edge
//   DATA_IN     in   [31:0] word data, sampled on the accepted edge
//   TR_IN_BUSY  out  holding register occupied
//   TX_DATA     out  [7:0] frame byte
//   TX_VALID    out  TX_DATA valid
//   TX_READY    in   sink accepts the byte when TX_VALID & TX_READY
//   FRAME_CNT   out  [31:0] completed frames, wrapping
//   DROP_CNT    out  [DROP_CNT_W-1:0] words lost to an offer while busy,
//                    saturating
// -----------------------------------------------------------------------------
module device_data_framer #(
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter int         DROP_CNT_W = 16
) (
    input  logic                  TR_CLK,
    input  logic                  RESET_N,
    input  logic                  TR_IN,
    input  logic [15:0]           ADDR_IN,
    input  logic [31:0]           DATA_IN,
    output logic                  TR_IN_BUSY,
    output logic [7:0]            TX_DATA,
    output logic                  TX_VALID,
    input  logic                  TX_READY,
    output logic [31:0]           FRAME_CNT,
    output logic [DROP_CNT_W-1:0] DROP_CNT
);

    typedef enum logic [3:0] {
        IDLE,
        SYNC,
        AH,
        AL,
        D3,
        D2,
        D1,
        D0,
        CHK
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic                    tr_in_d_reg;
    logic                    hold_full_reg;
    logic [47:0]             hold_word_reg;   // {ADDR, DATA}
    logic [47:0]             frame_word_reg;  // word currently being sent
    logic [7:0]              chk_reg;
    logic [31:0]             frame_cnt_reg;
    logic [DROP_CNT_W-1:0]   drop_cnt_reg;

    logic                    offer;
    logic                    chk_done;
    logic                    load;
    logic [7:0]              hold_byte [6];
    logic [7:0]              hold_sum;

    // Edge detector register resets to 1, so a strobe already high when reset
    // releases is not mistaken for a fresh offer.
    assign offer    = TR_IN & ~tr_in_d_reg;
    assign chk_done = (state_reg == CHK) & TX_READY;

    // The held word moves into the frame register whenever the FSM is free:
    // either idle, or finishing the checksum byte (back-to-back frames).
    assign load     = hold_full_reg & ((state_reg == IDLE) | chk_done);

    // Checksum is computed once at load time from the held word.
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_hold_bytes
            assign hold_byte[gi] = hold_word_reg[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        hold_sum = 8'h00;
        for (int i = 0; i < 6; i++) begin
            hold_sum = hold_sum + hold_byte[i];
        end
    end

    // Next-state logic: advance one byte per accepted handshake.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (hold_full_reg) state_next = SYNC;
            SYNC: if (TX_READY)      state_next = AH;
            AH:   if (TX_READY)      state_next = AL;
            AL:   if (TX_READY)      state_next = D3;
            D3:   if (TX_READY)      state_next = D2;
            D2:   if (TX_READY)      state_next = D1;
            D1:   if (TX_READY)      state_next = D0;
            D0:   if (TX_READY)      state_next = CHK;
            CHK:  if (TX_READY)      state_next = hold_full_reg ? SYNC : IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // Byte mux; depends only on registered state, so it is stable during stalls.
    always_comb begin
        TX_DATA = 8'h00;
        case (state_reg)
            SYNC:    TX_DATA = SYNC_BYTE;
            AH:      TX_DATA = frame_word_reg[47:40];
            AL:      TX_DATA = frame_word_reg[39:32];
            D3:      TX_DATA = frame_word_reg[31:24];
            D2:      TX_DATA = frame_word_reg[23:16];
            D1:      TX_DATA = frame_word_reg[15:8];
            D0:      TX_DATA = frame_word_reg[7:0];
            CHK:     TX_DATA = chk_reg;
            default: TX_DATA = 8'h00;
        endcase
    end

    always_ff @(posedge TR_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg      <= IDLE;
            tr_in_d_reg    <= 1'b1;
            hold_full_reg  <= 1'b0;
            hold_word_reg  <= '0;
            frame_word_reg <= '0;
            chk_reg        <= 8'h00;
            frame_cnt_reg  <= 32'd0;
            drop_cnt_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            tr_in_d_reg <= TR_IN;

            // Load requires a full holding register and capture requires an
            // empty one, so the two never happen in the same cycle.
            if (load) begin
                frame_word_reg <= hold_word_reg;
                chk_reg        <= hold_sum;
                hold_full_reg  <= 1'b0;
            end else if (offer && !hold_full_reg) begin
                hold_word_reg  <= {ADDR_IN, DATA_IN};
                hold_full_reg  <= 1'b1;
            end

            if (offer && hold_full_reg && (drop_cnt_reg != '1)) begin
                drop_cnt_reg <= drop_cnt_reg + DROP_CNT_W'(1);
            end

            if (chk_done) begin
                frame_cnt_reg <= frame_cnt_reg + 32'd1;
            end
        end
    end

    assign TX_VALID   = (state_reg != IDLE);
    assign TR_IN_BUSY = hold_full_reg;
    assign FRAME_CNT  = frame_cnt_reg;
    assign DROP_CNT   = drop_cnt_reg;

endmodule

// File: tb/tb_device_data_framer.sv
// -----------------------------------------------------------------------------
// tb_device_data_framer
//
// Self-checking bench for device_data_framer. A transaction-level reference
// model (a byte queue for the frame in flight plus a one-word holding slot)
// predicts TX_VALID/TX_DATA/TR_IN_BUSY/FRAME_CNT/DROP_CNT every cycle; directed
// scenarios additionally compare captured frames against literal byte strings.
// The drop counter width is reduced so that saturation is reached quickly; the
// saturating behaviour does not depend on the width.
// -----------------------------------------------------------------------------
module tb_device_data_framer;

    localparam logic [7:0] SYNC_B = 8'hA5;
    localparam int         DW     = 10;
    localparam int         DMAX   = (1 << DW) - 1;

    logic          TR_CLK = 1'b0;
    logic          RESET_N = 1'b0;
    logic          TR_IN = 1'b0;
    logic [15:0]   ADDR_IN = '0;
    logic [31:0]   DATA_IN = '0;
    logic          TR_IN_BUSY;
    logic [7:0]    TX_DATA;
    logic          TX_VALID;
    logic          TX_READY;
    logic [31:0]   FRAME_CNT;
    logic [DW-1:0] DROP_CNT;

    always #5 TR_CLK = ~TR_CLK;

    device_data_framer #(
        .SYNC_BYTE  (SYNC_B),
        .DROP_CNT_W (DW)
    ) dut (
        .TR_CLK     (TR_CLK),
        .RESET_N    (RESET_N),
        .TR_IN      (TR_IN),
        .ADDR_IN    (ADDR_IN),
        .DATA_IN    (DATA_IN),
        .TR_IN_BUSY (TR_IN_BUSY),
        .TX_DATA    (TX_DATA),
        .TX_VALID   (TX_VALID),
        .TX_READY   (TX_READY),
        .FRAME_CNT  (FRAME_CNT),
        .DROP_CNT   (DROP_CNT)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  m_bytes[$];   // remaining bytes of the frame on the wire
    logic        m_hold_v;
    logic [47:0] m_hold_w;
    logic        m_prev;
    logic [31:0] m_frames;
    int          m_drops;
    logic [7:0]  dut_log[$];   // bytes the DUT actually handed over

    task automatic push_frame(input logic [47:0] w);
        int s;
        s = 0;
        m_bytes.push_back(SYNC_B);
        for (int i = 5; i >= 0; i--) begin
            m_bytes.push_back(w[8*i +: 8]);
            s = s + int'(w[8*i +: 8]);
        end
        m_bytes.push_back(8'(s % 256));
    endtask

    task automatic model_step();
        logic        had_hold;
        logic [47:0] hw;
        logic        offer;
        logic        fsm_free;
        if (!RESET_N) begin
            m_bytes.delete();
            dut_log.delete();
            m_hold_v = 1'b0;
            m_hold_w = '0;
            m_prev   = 1'b1;
            m_frames = 32'd0;
            m_drops  = 0;
        end else begin
            if (TX_VALID && TX_READY) dut_log.push_back(TX_DATA);
            had_hold = m_hold_v;
            hw       = m_hold_w;
            offer    = TR_IN && !m_prev;
            m_prev   = TR_IN;
            fsm_free = (m_bytes.size() == 0);
            if (m_bytes.size() > 0 && TX_READY) begin
                void'(m_bytes.pop_front());
                if (m_bytes.size() == 0) begin
                    m_frames = m_frames + 32'd1;
                    fsm_free = 1'b1;
                    $display("frame %0d complete", m_frames);
                end
            end
            if (offer) begin
                if (had_hold) begin
                    if (m_drops < DMAX) m_drops++;
                end else begin
                    m_hold_v = 1'b1;
                    m_hold_w = {ADDR_IN, DATA_IN};
                end
            end
            if (had_hold && fsm_free) begin
                push_frame(hw);
                m_hold_v = 1'b0;
            end
        end
    endtask

    initial begin
        model_step();
        forever begin
            @(posedge TR_CLK or negedge RESET_N);
            model_step();
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge TR_CLK);
            if (RESET_N) begin
                check("tx_valid", TX_VALID, m_bytes.size() > 0);
                if (m_bytes.size() > 0) check("tx_data", TX_DATA, m_bytes[0]);
                check("busy", TR_IN_BUSY, m_hold_v);
                check("frame_cnt", FRAME_CNT, m_frames);
                check("drop_cnt", DROP_CNT, m_drops);
            end
        end
    end

    // ---------------- TX_READY driver ----------------
    int   rdy_mode = 0;    // 0: constant rdy_val, 1: 1-0-0-1 pattern, 2: random
    logic rdy_val  = 1'b1;
    initial begin
        logic [3:0] pat;
        int         cyc;
        pat = 4'b1001;
        cyc = 0;
        TX_READY = 1'b1;
        forever begin
            @(posedge TR_CLK);
            #1;
            case (rdy_mode)
                1:       TX_READY = pat[cyc % 4];
                2:       TX_READY = 1'($urandom_range(0, 1));
                default: TX_READY = rdy_val;
            endcase
            cyc++;
        end
    end

    // ---------------- helpers ----------------
    task automatic offer_word(input logic [15:0] a, input logic [31:0] d);
        @(posedge TR_CLK); #1;
        ADDR_IN = a;
        DATA_IN = d;
        TR_IN   = 1'b1;
        @(posedge TR_CLK); #1;
        TR_IN   = 1'b0;
        ADDR_IN = 16'($urandom);
        DATA_IN = $urandom;
    endtask

    task automatic expect_frame(input string tag, input logic [63:0] exp);
        int waited;
        waited = 0;
        while (dut_log.size() < 8 && waited < 400) begin
            @(negedge TR_CLK);
            waited++;
        end
        if (dut_log.size() < 8) begin
            check({tag, "_timeout"}, 64'(dut_log.size()), 64'd8);
        end else begin
            for (int i = 0; i < 8; i++) begin
                check(tag, dut_log.pop_front(), exp[63-8*i -: 8]);
            end
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge TR_CLK);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scenarios ----------------
    initial begin
        int waited;

        // Reset state
        RESET_N = 1'b0;
        rdy_mode = 0;
        rdy_val  = 1'b1;
        repeat (3) @(negedge TR_CLK);
        check("rst_valid", TX_VALID, 1'b0);
        check("rst_data", TX_DATA, 8'h00);
        check("rst_busy", TR_IN_BUSY, 1'b0);
        check("rst_frames", FRAME_CNT, 32'd0);
        check("rst_drops", DROP_CNT, 0);
        @(posedge TR_CLK); #1;
        RESET_N = 1'b1;
        wait_cycles(2);

        // 1: single word, sink always ready
        offer_word(16'h012C, 32'h12345678);
        expect_frame("t1_frame", 64'hA5_01_2C_12_34_56_78_41);
        wait_cycles(3);
        check("t1_frames", FRAME_CNT, 32'd1);

        // 2: same word, 1-0-0-1 ready pattern
        rdy_mode = 1;
        offer_word(16'h012C, 32'h12345678);
        expect_frame("t2_frame", 64'hA5_01_2C_12_34_56_78_41);
        rdy_mode = 0;
        wait_cycles(3);
        check("t2_frames", FRAME_CNT, 32'd2);

        // 3: stalled sink, A in frame, B held, C dropped
        rdy_val = 1'b0;
        wait_cycles(1);
        offer_word(16'h0001, 32'h00000001);
        offer_word(16'h0002, 32'h00000002);
        offer_word(16'h0003, 32'h00000003);
        @(negedge TR_CLK);
        check("t3_busy", TR_IN_BUSY, 1'b1);
        check("t3_drops", DROP_CNT, 1);
        check("t3_sync", TX_DATA, SYNC_B);
        @(posedge TR_CLK); #1;
        rdy_val = 1'b1;
        expect_frame("t3_frameA", 64'hA5_00_01_00_00_00_01_02);
        expect_frame("t3_frameB", 64'hA5_00_02_00_00_00_02_04);
        wait_cycles(3);
        check("t3_frames", FRAME_CNT, 32'd4);

        // 4a: TR_IN held high for 5 cycles -> one frame only
        @(posedge TR_CLK); #1;
        ADDR_IN = 16'h1234;
        DATA_IN = 32'h00000000;
        TR_IN   = 1'b1;
        wait_cycles(5);
        TR_IN   = 1'b0;
        expect_frame("t4_frame", 64'hA5_12_34_00_00_00_00_46);
        wait_cycles(20);
        check("t4_single", 64'(dut_log.size()), 64'd0);
        check("t4_drops", DROP_CNT, 1);
        check("t4_frames", FRAME_CNT, 32'd5);

        // 4b: TR_IN high across reset release is ignored until it drops
        TR_IN = 1'b1;
        @(posedge TR_CLK); #1;
        RESET_N = 1'b0;
        wait_cycles(3);
        RESET_N = 1'b1;
        wait_cycles(15);
        check("t4_noframe", FRAME_CNT, 32'd0);
        check("t4_nolog", 64'(dut_log.size()), 64'd0);
        check("t4_idle", TX_VALID, 1'b0);
        TR_IN = 1'b0;
        offer_word(16'hBEEF, 32'hCAFEF00D);
        expect_frame("t4_fresh", 64'hA5_BE_EF_CA_FE_F0_0D_72);

        // 5: reset while the D2 byte is on the wire
        offer_word(16'h5555, 32'hAAAA5555);
        waited = 0;
        while (dut_log.size() < 4 && waited < 100) begin
            @(negedge TR_CLK);
            waited++;
        end
        check("t5_reach_d2", TX_DATA, 8'hAA);
        RESET_N = 1'b0;
        #1;
        check("t5_valid", TX_VALID, 1'b0);
        check("t5_frames", FRAME_CNT, 32'd0);
        check("t5_drops", DROP_CNT, 0);
        check("t5_busy", TR_IN_BUSY, 1'b0);
        wait_cycles(3);
        RESET_N = 1'b1;
        wait_cycles(2);
        offer_word(16'hFFFF, 32'hFFFFFFFF);
        expect_frame("t5_frame", 64'hA5_FF_FF_FF_FF_FF_FF_FA);

        // 6: drop counter saturation
        rdy_val = 1'b0;
        wait_cycles(1);
        offer_word(16'h0010, 32'h00000020);
        offer_word(16'h0030, 32'h00000040);
        for (int i = 0; i < DMAX + 6; i++) begin
            offer_word(16'($urandom), $urandom);
        end
        @(negedge TR_CLK);
        check("t6_sat", DROP_CNT, DMAX);
        @(posedge TR_CLK); #1;
        rdy_val = 1'b1;
        expect_frame("t6_frameA", 64'hA5_00_10_00_00_00_20_30);
        expect_frame("t6_frameB", 64'hA5_00_30_00_00_00_40_70);
        offer_word(16'h0001, 32'h00000001);
        check("t6_still_sat", DROP_CNT, DMAX);
        expect_frame("t6_frameC", 64'hA5_00_01_00_00_00_01_02);

        // Random traffic against the model
        do_random_reset();
        rdy_mode = 2;
        for (int i = 0; i < 1500; i++) begin
            @(posedge TR_CLK); #1;
            if ($urandom_range(0, 3) == 0) TR_IN = ~TR_IN;
            ADDR_IN = 16'($urandom);
            DATA_IN = $urandom;
        end
        TR_IN    = 1'b0;
        rdy_mode = 0;
        rdy_val  = 1'b1;
        wait_cycles(30);
        check("rnd_drained", TX_VALID, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    task automatic do_random_reset();
        @(posedge TR_CLK); #1;
        RESET_N = 1'b0;
        wait_cycles(2);
        RESET_N = 1'b1;
        wait_cycles(2);
    endtask

endmodule
